// File: rtl/list_pkg.sv
// Shared types and constants for the linked-list search controller.
package list_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    // Word offsets within a node: value first, next pointer second.
    localparam logic [ADDR_W-1:0] NODE_VAL_OFS  = 16'd0;
    localparam logic [ADDR_W-1:0] NODE_NEXT_OFS = 16'd1;

    localparam logic [ADDR_W-1:0] NULL_ADDR_DEFAULT = 16'h0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_VAL,
        S_REQ_NEXT,
        S_EVAL,
        S_DONE
    } state_t;

endpackage

// File: rtl/CheckValue.sv
// Per-node check stage: compares the node value against the key and forwards the next pointer.
module CheckValue
    import list_pkg::*;
(
    input  logic [DATA_W-1:0] CurrentNode,
    input  logic [DATA_W-1:0] ValuetoFind,
    input  logic [ADDR_W-1:0] NextAddressNode,
    output logic              Match,
    output logic [ADDR_W-1:0] NextAddress
);

    always_comb begin
        Match       = (CurrentNode == ValuetoFind);
        NextAddress = NextAddressNode;
    end

endmodule

// File: rtl/list_search_fsm.sv
// Walks a singly linked list in 1-cycle-latency RAM until match, null pointer or step limit.
module list_search_fsm
    import list_pkg::*;
#(
    parameter int unsigned        MAX_STEPS = 1024,
    parameter logic [ADDR_W-1:0]  NULL_ADDR = NULL_ADDR_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] value_to_find,
    input  logic [ADDR_W-1:0] head_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] found_addr,
    output logic              timeout,
    output logic [15:0]       steps
);

    localparam logic [16:0] MAX_STEPS_W = 17'(MAX_STEPS);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic [ADDR_W-1:0] node_q, node_d;
    logic [ADDR_W-1:0] found_addr_q, found_addr_d;
    logic              found_q, found_d;
    logic              timeout_q, timeout_d;
    logic [15:0]       steps_q, steps_d;

    logic              match;
    logic [ADDR_W-1:0] next_addr;
    logic [16:0]       steps_inc;

    CheckValue u_check (
        .CurrentNode     (val_q),
        .ValuetoFind     (key_q),
        .NextAddressNode (mem_rdata),
        .Match           (match),
        .NextAddress     (next_addr)
    );

    // Widened so the limit compare cannot alias when MAX_STEPS is 65535.
    assign steps_inc = {1'b0, steps_q} + 17'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            key_q        <= '0;
            val_q        <= '0;
            node_q       <= '0;
            found_addr_q <= '0;
            found_q      <= 1'b0;
            timeout_q    <= 1'b0;
            steps_q      <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            val_q        <= val_d;
            node_q       <= node_d;
            found_addr_q <= found_addr_d;
            found_q      <= found_d;
            timeout_q    <= timeout_d;
            steps_q      <= steps_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        val_d        = val_q;
        node_d       = node_q;
        found_addr_d = found_addr_q;
        found_d      = found_q;
        timeout_d    = timeout_q;
        steps_d      = steps_q;
        mem_rd       = 1'b0;
        mem_addr     = '0;
        done         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d        = value_to_find;
                    node_d       = head_addr;
                    found_d      = 1'b0;
                    found_addr_d = '0;
                    timeout_d    = 1'b0;
                    steps_d      = '0;
                    state_d      = (head_addr == NULL_ADDR) ? S_DONE : S_REQ_VAL;
                end
            end
            S_REQ_VAL: begin
                mem_rd   = 1'b1;
                mem_addr = node_q + NODE_VAL_OFS;
                state_d  = S_REQ_NEXT;
            end
            S_REQ_NEXT: begin
                mem_rd   = 1'b1;
                mem_addr = node_q + NODE_NEXT_OFS;
                val_d    = mem_rdata;
                state_d  = S_EVAL;
            end
            S_EVAL: begin
                // Priority: match, then null pointer, then step limit.
                steps_d = steps_inc[15:0];
                if (match) begin
                    found_d      = 1'b1;
                    found_addr_d = node_q;
                    state_d      = S_DONE;
                end else if (next_addr == NULL_ADDR) begin
                    state_d = S_DONE;
                end else if (steps_inc == MAX_STEPS_W) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    node_d  = next_addr;
                    state_d = S_REQ_VAL;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign found      = found_q;
    assign found_addr = found_addr_q;
    assign timeout    = timeout_q;
    assign steps      = steps_q;

endmodule

// File: tb/tb_list_search_fsm.sv
// Directed bench for list_search_fsm with a 1-cycle-latency RAM model (MAX_STEPS=4).
module tb_list_search_fsm;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] value_to_find;
    logic [15:0] head_addr;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        found;
    logic [15:0] found_addr;
    logic        timeout;
    logic [15:0] steps;

    logic [15:0] mem [0:65535];
    logic [15:0] addr_q [$];
    int          checks = 0;
    int          errors = 0;
    int          repulse_at = 0;
    int          lat;

    list_search_fsm #(.MAX_STEPS(4), .NULL_ADDR(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .value_to_find (value_to_find),
        .head_addr     (head_addr),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .busy          (busy),
        .done          (done),
        .found         (found),
        .found_addr    (found_addr),
        .timeout       (timeout),
        .steps         (steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts negedges after the start cycle until done; optional start re-pulse while busy.
    task automatic wait_done(output int latency);
        latency = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (repulse_at != 0 && i == repulse_at) begin
                start = 1'b1;
                value_to_find = 16'h0009;
                head_addr = 16'h0000;
            end
            if (repulse_at != 0 && i == repulse_at + 1) start = 1'b0;
            if (mem_rd) addr_q.push_back(mem_addr);
            if (done) begin
                latency = i;
                break;
            end
        end
    endtask

    task automatic run_search(input logic [15:0] key, input logic [15:0] head, output int latency);
        @(negedge clk);
        value_to_find = key;
        head_addr = head;
        start = 1'b1;
        addr_q.delete();
        wait_done(latency);
    endtask

    initial begin
        logic [15:0] exp_addr [6];
        rst = 1'b1;
        start = 1'b0;
        value_to_find = '0;
        head_addr = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_steps", 32'(steps), 0);
        rst = 1'b0;

        // Single-node match
        mem[16'h0010] = 16'h1234;
        mem[16'h0011] = 16'h0000;
        run_search(16'h1234, 16'h0010, lat);
        chk("one_lat", 32'(lat), 4);
        chk("one_found", 32'(found), 1);
        chk("one_faddr", 32'(found_addr), 32'h0010);
        chk("one_steps", 32'(steps), 1);
        chk("one_timeout", 32'(timeout), 0);
        @(negedge clk);
        chk("one_done_pulse", 32'(done), 0);
        chk("one_idle", 32'(busy), 0);

        // Three-node walk
        mem[16'h0010] = 16'h0005; mem[16'h0011] = 16'h0020;
        mem[16'h0020] = 16'h0007; mem[16'h0021] = 16'h0030;
        mem[16'h0030] = 16'h0009; mem[16'h0031] = 16'h0000;
        run_search(16'h0009, 16'h0010, lat);
        chk("three_lat", 32'(lat), 10);
        chk("three_faddr", 32'(found_addr), 32'h0030);
        chk("three_steps", 32'(steps), 3);
        exp_addr = '{16'h0010, 16'h0011, 16'h0020, 16'h0021, 16'h0030, 16'h0031};
        chk("three_nrd", 32'(addr_q.size()), 6);
        for (int i = 0; i < 6 && i < addr_q.size(); i++) chk("three_addr", 32'(addr_q[i]), 32'(exp_addr[i]));

        // Miss to null
        run_search(16'hBEEF, 16'h0010, lat);
        chk("miss_lat", 32'(lat), 10);
        chk("miss_found", 32'(found), 0);
        chk("miss_faddr", 32'(found_addr), 0);
        chk("miss_steps", 32'(steps), 3);
        chk("miss_timeout", 32'(timeout), 0);

        // Null head
        run_search(16'h0005, 16'h0000, lat);
        chk("null_lat", 32'(lat), 1);
        chk("null_steps", 32'(steps), 0);
        chk("null_nrd", 32'(addr_q.size()), 0);
        chk("null_found", 32'(found), 0);

        // Re-pulse while busy must not disturb the walk
        repulse_at = 2;
        run_search(16'h0007, 16'h0010, lat);
        repulse_at = 0;
        chk("rep_lat", 32'(lat), 7);
        chk("rep_found", 32'(found), 1);
        chk("rep_faddr", 32'(found_addr), 32'h0020);
        chk("rep_steps", 32'(steps), 2);

        // Start during done ignored; start the cycle after done accepted
        start = 1'b1;
        value_to_find = 16'h0005;
        head_addr = 16'h0010;
        @(negedge clk);
        chk("sd_ignored_busy", 32'(busy), 0);
        chk("sd_hold_faddr", 32'(found_addr), 32'h0020);
        addr_q.delete();
        wait_done(lat);
        chk("sa_lat", 32'(lat), 4);
        chk("sa_first_addr", 32'(addr_q.size() > 0 ? addr_q[0] : 16'hDEAD), 32'h0010);
        chk("sa_faddr", 32'(found_addr), 32'h0010);
        chk("sa_steps", 32'(steps), 1);

        // Null at the step limit beats timeout; match at the limit beats timeout
        mem[16'h0031] = 16'h0040;
        mem[16'h0040] = 16'h000B; mem[16'h0041] = 16'h0000;
        run_search(16'hAAAA, 16'h0010, lat);
        chk("lim_null_lat", 32'(lat), 13);
        chk("lim_null_timeout", 32'(timeout), 0);
        chk("lim_null_steps", 32'(steps), 4);
        run_search(16'h000B, 16'h0010, lat);
        chk("lim_match_found", 32'(found), 1);
        chk("lim_match_faddr", 32'(found_addr), 32'h0040);
        chk("lim_match_timeout", 32'(timeout), 0);

        // Cyclic list times out
        mem[16'h0021] = 16'h0010;
        run_search(16'hAAAA, 16'h0010, lat);
        chk("cyc_lat", 32'(lat), 13);
        chk("cyc_timeout", 32'(timeout), 1);
        chk("cyc_steps", 32'(steps), 4);
        chk("cyc_found", 32'(found), 0);

        // Reset mid-walk during REQ_NEXT
        @(negedge clk);
        value_to_find = 16'h0009;
        head_addr = 16'h0010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rm_in_req_next", 32'(mem_addr), 32'h0011);
        rst = 1'b1;
        @(negedge clk);
        chk("rm_busy", 32'(busy), 0);
        chk("rm_mem_rd", 32'(mem_rd), 0);
        chk("rm_mem_addr", 32'(mem_addr), 0);
        chk("rm_outs", 32'({done, found, timeout, found_addr, steps}), 0);
        rst = 1'b0;

        // Address wrap
        mem[16'hFFFF] = 16'h7777;
        mem[16'h0000] = 16'h0000;
        run_search(16'h7777, 16'hFFFF, lat);
        chk("wrap_lat", 32'(lat), 4);
        chk("wrap_found", 32'(found), 1);
        chk("wrap_faddr", 32'(found_addr), 32'hFFFF);
        chk("wrap_nrd", 32'(addr_q.size()), 2);
        chk("wrap_addr1", 32'(addr_q.size() > 1 ? addr_q[1] : 16'hDEAD), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/list_search_fsm.md
Name: list_search_fsm

Overview:
- Sequential linked-list search controller that walks a singly linked list held in synchronous RAM.
- For each node it fetches the value word and the next-pointer word, then drives the existing per-node check stage (CheckValue), which does the compare and passes the next address through.
- It follows next pointers until it finds a match, reaches a null pointer, or hits a step limit.
- It sits directly upstream of the node-check stage and owns the RAM read port during a search.

Parameters:
- MAX_STEPS, 1024: maximum nodes examined per search before timeout; legal range 1..65535.
- NULL_ADDR, 16'h0000: pointer value that terminates the list.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a search; sampled only in IDLE.
- value_to_find  in  16  search key; latched on accepted start.
- head_addr  in  16  address of first node; latched on accepted start.
- mem_rd  out  1  RAM read strobe.
- mem_addr  out  16  RAM read address.
- mem_rdata  in  16  RAM read data; valid the cycle after mem_rd=1 (1-cycle latency).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- found  out  1  key matched; valid from done until next accepted start.
- found_addr  out  16  address of the matching node; 0 when not found.
- timeout  out  1  step limit reached without match or null.
- steps  out  16  nodes examined in the last or current search.

Behaviour:
- Reset: state IDLE; all outputs 0; internal key, node and value registers 0. Reset applies in any state and aborts a search mid-walk. mem_rd=0 in the cycle after reset.
- Node layout: word at A holds the value; word at A+1 holds the next pointer. A+1 is computed mod 2^16, so 16'hFFFF+1 = 16'h0000.
- States: IDLE, REQ_VAL, REQ_NEXT, EVAL, DONE.
- IDLE:
  - start=1 latches the key and node=head_addr, clears found, found_addr, timeout and steps.
  - If head_addr==NULL_ADDR, go to DONE with found=0. Otherwise go to REQ_VAL.
  - start is ignored in all other states.
- REQ_VAL: mem_rd=1, mem_addr=node; go to REQ_NEXT.
- REQ_NEXT: mem_rd=1, mem_addr=node+1; capture val_reg=mem_rdata; go to EVAL.
- EVAL:
  - mem_rd=0; mem_rdata is the next pointer; steps increments by 1.
  - CurrentNode=val_reg, ValuetoFind=key, NextAddressNode=mem_rdata.
  - Match: found=1, found_addr=node, go to DONE.
  - Else if next==NULL_ADDR: go to DONE with found=0.
  - Else if steps+1==MAX_STEPS: timeout=1, go to DONE.
  - Else: node=next, go to REQ_VAL.
  - Match has priority over null, and null has priority over timeout.
- DONE: done=1 for exactly one cycle, then IDLE. found, found_addr, timeout and steps hold until the next accepted start.
- mem_addr=0 whenever mem_rd=0.
- Latency from start (cycle T):
  - Match at node k (1-based): done at T+1+3k.
  - Null head: done at T+1.
- Cyclic lists always terminate via MAX_STEPS.
- A start asserted in the same cycle as done is ignored.
- A start asserted the cycle after done is accepted.

Decomposition:
- Shared package list_pkg:
  - state enum.
  - NODE_VAL_OFS=0, NODE_NEXT_OFS=1.
  - NULL_ADDR default.
  - ADDR_W=16, DATA_W=16.
- One sub-module: the existing CheckValue node-check stage, instantiated once for the equality compare and next-address pass-through.
- Step counter and FSM stay in this module.

Test Plan:
- Single-node match: head=0x0010, mem[0x10]=0x1234, mem[0x11]=0; key 0x1234 -> done at T+4, found=1, found_addr=0x0010, steps=1, timeout=0.
- Three-node walk: 0x10→0x20→0x30, values 5, 7, 9; key 9 -> done at T+10, found_addr=0x0030, steps=3. Also check mem_addr sequence 10, 11, 20, 21, 30, 31.
- Miss to null: same list, key 0xBEEF -> done at T+10, found=0, found_addr=0, steps=3, timeout=0.
- Null head and ignored start: head=0 -> done at T+1, steps=0, no mem_rd. Re-pulse start while busy -> no effect on walk or results.
- Cycle and timeout: MAX_STEPS=4, list 0x10→0x20→0x10 cycle, key absent -> done at T+13, timeout=1, steps=4.
- Reset mid-walk and address wrap:
  - Assert rst during REQ_NEXT -> next cycle IDLE, busy=0, mem_rd=0, all outputs 0.
  - Then search head=0xFFFF with mem[0xFFFF]=key and mem[0x0000]=0 -> found_addr=0xFFFF, second read at 0x0000.
